// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matvec_mul controller.
package matvec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Datapath latency: one multiply register plus one register per adder-tree level.
    function automatic int calc_lat(input int c);
        return $clog2(c) + 1;
    endfunction

endpackage

// File: rtl/matvec_vld_pipe.sv
// Enable-gated valid shift register tracking results through the matvec_mul datapath.
module matvec_vld_pipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] vld;

    // Shift only on enabled cycles so valid bits stay aligned with the stalled datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    assign dout = vld[LAT-1];

endmodule

// File: rtl/matvec_ctrl.sv
// Batch controller for the matvec_mul datapath: accepts num_vec input vectors,
// drives the datapath clock enable and tracks results until all are consumed.
// Optional build macro MATVEC_CTRL_PERF_EN adds stall_cnt / bubble_cnt outputs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; num_vec captured on start
// ST_RUN   | accepting x/k until num_vec_q vectors have been taken
// ST_DRAIN | all inputs taken; waiting for remaining results to be consumed
// ST_DONE  | one-cycle done pulse, then back to idle
module matvec_ctrl
    import matvec_pkg::*;
#(
    parameter int C    = 8,
    parameter int NV_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NV_W-1:0] num_vec,
    output logic            busy,
    output logic            done,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            mm_cen
`ifdef MATVEC_CTRL_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int LAT = calc_lat(C);

    state_t          state_q;
    state_t          state_d;
    logic            start_acc;
    logic [NV_W-1:0] num_vec_q;
    logic [NV_W-1:0] acc_cnt;
    logic [NV_W-1:0] emit_cnt;
    logic [NV_W-1:0] emit_nxt;
    logic            accept;
    logic            emit;
    logic            active;

    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // Stall only while an unconsumed result sits at the datapath output.
    assign mm_cen   = !(m_valid && !m_ready);
    assign s_ready  = (state_q == ST_RUN) && mm_cen && (acc_cnt < num_vec_q);
    assign accept   = s_valid && s_ready;
    assign emit     = active && m_valid && m_ready;
    assign emit_nxt = emit_cnt + {{(NV_W-1){1'b0}}, emit};
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    matvec_vld_pipe #(
        .LAT (LAT)
    ) u_vld_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (mm_cen),
        .din  (accept),
        .dout (m_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the drain exit looks at the post-emit count so done
    // follows the last consumed result by exactly one cycle.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (acc_cnt == num_vec_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (emit_nxt == num_vec_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Batch size capture and accept/emit counters, cleared when a batch starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_vec_q <= '0;
            acc_cnt   <= '0;
            emit_cnt  <= '0;
        end else if (start_acc) begin
            num_vec_q <= num_vec;
            acc_cnt   <= '0;
            emit_cnt  <= '0;
        end else begin
            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (emit) begin
                emit_cnt <= emit_nxt;
            end
        end
    end

`ifdef MATVEC_CTRL_PERF_EN
    // Saturating stall and bubble counters, cleared on batch start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (busy && !mm_cen && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((state_q == ST_RUN) && s_ready && !s_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matvec_ctrl.sv
// Self-checking bench for matvec_ctrl: per-cycle signal masks against expected
// timelines, plus a tag scoreboard through a stand-in datapath pipeline.
module tb_matvec_ctrl;
    import matvec_pkg::*;

    localparam int C    = 8;
    localparam int NV_W = 16;
    localparam int LAT  = calc_lat(C);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NV_W-1:0] num_vec;
    logic            busy;
    logic            done;
    logic            s_valid;
    logic            s_ready;
    logic            m_valid;
    logic            m_ready;
    logic            mm_cen;
`ifdef MATVEC_CTRL_PERF_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     bubble_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_acc, m_val, m_done, m_busy, m_ncen, m_srdy;

    // stand-in datapath: tag pipeline gated by mm_cen
    logic [7:0] dp [LAT];
    logic [7:0] y_tag;
    logic [7:0] next_tag = 8'd0;
    logic [7:0] snap_tag = 8'd0;
    logic       snap_cen = 1'b0;
    logic [7:0] sb_q [$];
    logic [7:0] exp_tag;

    always #5 clk = ~clk;

    matvec_ctrl #(.C(C), .NV_W(NV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .mm_cen     (mm_cen)
`ifdef MATVEC_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    assign y_tag = dp[LAT-1];

    always @(posedge clk) begin
        if (snap_cen) begin
            dp[0] <= snap_tag;
            for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst) begin
            sb_q.delete();
            snap_cen = 1'b0;
        end else begin
            snap_cen = mm_cen;
            snap_tag = next_tag;
            if (m_valid && m_ready) begin
                chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    exp_tag = sb_q.pop_front();
                    chk("sb_tag", {24'd0, y_tag}, {24'd0, exp_tag});
                end
            end
            if (s_valid && s_ready) begin
                sb_q.push_back(next_tag);
                next_tag = next_tag + 8'd1;
            end
        end
    end

    // Cycle 0 carries start; later cycles follow the s_valid/m_ready drop masks.
    task automatic run(input logic [NV_W-1:0] nv, input int ncyc,
                       input logic [31:0] sv_off, input logic [31:0] mr_off,
                       input int start_at);
        m_acc = '0; m_val = '0; m_done = '0; m_busy = '0; m_ncen = '0; m_srdy = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start   = (c == 0) || (start_at != 0 && c == start_at);
            num_vec = (c == 0) ? nv : NV_W'(5);
            s_valid = !sv_off[c];
            m_ready = !mr_off[c];
            #1;
            m_acc[c]  = s_valid && s_ready;
            m_val[c]  = m_valid;
            m_done[c] = done;
            m_busy[c] = busy;
            m_ncen[c] = !mm_cen;
            m_srdy[c] = s_ready;
        end
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] seen;
        rst = 1'b1; start = 1'b0; num_vec = '0; s_valid = 1'b1; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_mm_cen",  {31'd0, mm_cen},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);

        // three vectors, no stalls
        run(16'd3, 12, 32'h0, 32'h0, 0);
        chk("b3_acc",  m_acc,  32'h0000_000E);
        chk("b3_mval", m_val,  32'h0000_00E0);
        chk("b3_done", m_done, 32'h0000_0100);
        chk("b3_busy", m_busy, 32'h0000_01FE);

        // empty batch
        run(16'd0, 5, 32'h0, 32'h0, 0);
        chk("b0_srdy", m_srdy, 32'h0);
        chk("b0_done", m_done, 32'h2);
        chk("b0_busy", m_busy, 32'h2);

        // downstream stall of five cycles on the first result
        run(16'd2, 16, 32'h0, 32'h3E0, 0);
        chk("st_acc",  m_acc,  32'h0000_0006);
        chk("st_ncen", m_ncen, 32'h0000_03E0);
        chk("st_mval", m_val,  32'h0000_0FE0);
        chk("st_done", m_done, 32'h0000_1000);
`ifdef MATVEC_CTRL_PERF_EN
        chk("st_stall_cnt", stall_cnt, 32'd5);
`endif

        // upstream drops s_valid for two RUN cycles
        run(16'd4, 14, 32'hC, 32'h0, 0);
        chk("bu_acc",  m_acc,  32'h0000_0072);
        chk("bu_mval", m_val,  32'h0000_0720);
        chk("bu_done", m_done, 32'h0000_0800);
`ifdef MATVEC_CTRL_PERF_EN
        chk("bu_bubble_cnt", bubble_cnt, 32'd2);
        chk("bu_stall_cnt",  stall_cnt,  32'd0);
`endif

        // start while busy is ignored
        run(16'd2, 10, 32'h0, 32'h0, 2);
        chk("rs_acc",  m_acc,  32'h0000_0006);
        chk("rs_mval", m_val,  32'h0000_0060);
        chk("rs_done", m_done, 32'h0000_0080);

        // reset two cycles after the first accept of a four-vector batch
        m_acc = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = (c == 0); num_vec = 16'd4; s_valid = 1'b1; m_ready = 1'b1;
            #1;
            m_acc[c] = s_valid && s_ready;
        end
        chk("mr_acc", m_acc, 32'h6);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_busy",    {31'd0, busy},    32'd0);
        chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mr_s_ready", {31'd0, s_ready}, 32'd0);
        chk("mr_mm_cen",  {31'd0, mm_cen},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            seen[0] = seen[0] | m_valid;
            seen[1] = seen[1] | busy;
        end
        chk("mr_quiet", seen, 32'h0);

        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
